// File: rtl/mac_arb_pkg.sv
// rtl/mac_arb_pkg.sv - shared constants, stage record and saturation helper for mac_arbiter
package mac_arb_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int LATENCY_DEF = 2;

   localparam int A_IN_W   = 17;
   localparam int B_W      = 16;
   localparam int RSP_W    = 16;
   localparam int ID_MAX_W = 3;

   typedef struct packed {
      logic                valid;
      logic [ID_MAX_W-1:0] id;
      logic [RSP_W-1:0]    data;
   } stage_t;

   // Clamp a 17-bit two's-complement value into the 16-bit signed range.
   function automatic logic [15:0] sat16(input logic [16:0] x);
      logic [15:0] r;
      if (x[16] != x[15]) begin
         r = x[16] ? 16'h8000 : 16'h7FFF;
      end else begin
         r = x[15:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - LATENCY-deep signed x unsigned multiplier with valid/id sideband
module mac_pipe
   import mac_arb_pkg::*;
#(
   parameter int LATENCY = LATENCY_DEF,
   parameter int ID_W    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [ID_W-1:0]  in_id,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   output logic             out_valid,
   output logic [ID_W-1:0]  out_id,
   output logic [RSP_W-1:0] out_data,
   output logic             busy
);

   // With LATENCY 1 the product register is the only stage; otherwise an
   // operand register sits in front of it, as the DSP block expects.
   localparam int NST = (LATENCY > 1) ? LATENCY - 1 : 1;

   logic              mul_valid;
   logic [ID_W-1:0]   mul_id;
   logic [15:0]       mul_a;
   logic [15:0]       mul_b;
   logic              in_busy;
   logic signed [31:0] prod;
   logic              unused_prod_lo;
   logic              unused_id_hi;

   stage_t st_q [NST];

   generate
      if (LATENCY > 1) begin : g_in_reg
         logic            valid_q;
         logic [ID_W-1:0] id_q;
         logic [15:0]     a_q;
         logic [15:0]     b_q;

         // Operand register; sideband and operands only load on a valid issue.
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_q <= 1'b0;
               id_q    <= '0;
               a_q     <= '0;
               b_q     <= '0;
            end else begin
               valid_q <= in_valid;
               if (in_valid) begin
                  id_q <= in_id;
                  a_q  <= in_a;
                  b_q  <= in_b;
               end
            end
         end

         assign mul_valid = valid_q;
         assign mul_id    = id_q;
         assign mul_a     = a_q;
         assign mul_b     = b_q;
         assign in_busy   = valid_q;
      end else begin : g_no_in_reg
         assign mul_valid = in_valid;
         assign mul_id    = in_id;
         assign mul_a     = in_a;
         assign mul_b     = in_b;
         assign in_busy   = 1'b0;
      end
   endgenerate

   // The full product always fits in 32 signed bits, so the high half is an
   // arithmetic floor of (a*b)/65536.
   assign prod = $signed({{16{mul_a[15]}}, mul_a}) * $signed({16'h0000, mul_b});
   assign unused_prod_lo = ^prod[15:0];

   // Product register followed by plain delay stages; id/data hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < NST; j++) begin
            st_q[j] <= '0;
         end
      end else begin
         st_q[0].valid <= mul_valid;
         if (mul_valid) begin
            st_q[0].id   <= ID_MAX_W'(mul_id);
            st_q[0].data <= prod[31:16];
         end
         for (int j = 1; j < NST; j++) begin
            st_q[j].valid <= st_q[j-1].valid;
            if (st_q[j-1].valid) begin
               st_q[j].id   <= st_q[j-1].id;
               st_q[j].data <= st_q[j-1].data;
            end
         end
      end
   end

   assign out_valid    = st_q[NST-1].valid;
   assign out_id       = st_q[NST-1].id[ID_W-1:0];
   assign out_data     = st_q[NST-1].data;
   assign unused_id_hi = ^st_q[NST-1].id;

   // Pipeline occupancy across the operand register and every product stage.
   always_comb begin
      busy = in_busy;
      for (int j = 0; j < NST; j++) begin
         busy = busy | st_q[j].valid;
      end
   end

endmodule

// File: rtl/mac_arbiter.sv
// rtl/mac_arbiter.sv - round-robin front end sharing one multiplier; MAC_ARB_SAT_EN enables 17->16 bit operand saturation
module mac_arbiter
   import mac_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int LATENCY = LATENCY_DEF,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*A_IN_W-1:0] req_a,
   input  logic [NUM_REQ*B_W-1:0]    req_b,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [RSP_W-1:0]          rsp_data,
   output logic                      busy
);

   logic [ID_W-1:0]   ptr_q;
   logic [ID_W-1:0]   ptr_d;
   logic [ID_W-1:0]   win_id;
   logic              xfer;
   logic [A_IN_W-1:0] a_sel;
   logic [B_W-1:0]    b_sel;
   logic [15:0]       a_iss;

   // Rotating-priority search: first valid requester at or after ptr_q wins.
   always_comb begin
      logic [ID_W:0]   sum;
      logic [ID_W-1:0] idx;
      req_ready = '0;
      xfer      = 1'b0;
      win_id    = '0;
      a_sel     = '0;
      b_sel     = '0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
         end
         idx = sum[ID_W-1:0];
         if (!xfer && req_valid[idx]) begin
            xfer           = 1'b1;
            req_ready[idx] = 1'b1;
            win_id         = idx;
            a_sel          = req_a[idx*A_IN_W +: A_IN_W];
            b_sel          = req_b[idx*B_W +: B_W];
         end
      end
   end

   // Next pointer: one past the winner, wrapping at NUM_REQ; hold when idle.
   always_comb begin
      ptr_d = ptr_q;
      if (xfer) begin
         if (win_id == ID_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = win_id + ID_W'(1);
         end
      end
   end

   // Pointer register; reset overrides any transfer seen in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

`ifdef MAC_ARB_SAT_EN
   assign a_iss = sat16(a_sel);
`else
   logic unused_a_msb;
   assign a_iss        = a_sel[15:0];
   assign unused_a_msb = a_sel[16];
`endif

   mac_pipe #(
      .LATENCY (LATENCY),
      .ID_W    (ID_W)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (xfer),
      .in_id     (win_id),
      .in_a      (a_iss),
      .in_b      (b_sel),
      .out_valid (rsp_valid),
      .out_id    (rsp_id),
      .out_data  (rsp_data),
      .busy      (busy)
   );

endmodule
